// File: rtl/allpass_pkg.sv
// allpass_pkg -- shared definitions for the multi-channel allpass filter.
//   state_e    : FSM states of the sample engine (IDLE, MAC, OUT)
//   acc_width  : accumulator width that cannot overflow for the given sizes
//   round_sat  : round-half-up, arithmetic shift and saturate to a sample width
package allpass_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  // Width of the accumulator. It holds 2*ORDER+1 full-precision products plus a guard bit.
  function automatic int acc_width(input int width, input int cwidth, input int order);
    return width + cwidth + $clog2(2 * order + 1) + 1;
  endfunction

  // Fixed 128-bit working width. The caller passes the accumulator sign-extended to
  // 128 bits and truncates the result to the sample width. frac must be >= 1.
  function automatic logic signed [127:0] round_sat(input logic signed [127:0] acc,
                                                    input int frac, input int width);
    logic signed [127:0] r;
    logic signed [127:0] hi;
    logic signed [127:0] lo;
    r  = (acc + (128'sd1 <<< (frac - 1))) >>> frac;
    hi = (128'sd1 <<< (width - 1)) - 128'sd1;
    lo = -(128'sd1 <<< (width - 1));
    if (r > hi) begin
      r = hi;
    end else if (r < lo) begin
      r = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/allpass_coef_bank.sv
// allpass_coef_bank -- shadow/active coefficient registers with commit logic.
//   clk, rst (async, active-low)
//   coef_we/coef_addr/coef_data : write one shadow tap (addresses above ORDER are ignored)
//   coef_commit                 : request a shadow -> active copy
//   commit_en                   : copy may happen this cycle (engine idle)
//   rd_idx_a/b, rd_coef_a/b     : two combinational read ports on the active bank
module allpass_coef_bank
  import allpass_pkg::*;
#(
  parameter int CWIDTH = 16,
  parameter int ORDER  = 4,
  parameter int AW     = $clog2(ORDER + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     coef_we,
  input  logic [AW-1:0]            coef_addr,
  input  logic signed [CWIDTH-1:0] coef_data,
  input  logic                     coef_commit,
  input  logic                     commit_en,
  input  logic [AW-1:0]            rd_idx_a,
  input  logic [AW-1:0]            rd_idx_b,
  output logic signed [CWIDTH-1:0] rd_coef_a,
  output logic signed [CWIDTH-1:0] rd_coef_b
);

  logic pend_q, pend_d;
  logic copy;
  logic signed [CWIDTH-1:0] act_w [2**AW];

  // A commit seen while the engine is busy waits in pend_q until the next idle cycle.
  assign copy   = commit_en && (pend_q || coef_commit);
  assign pend_d = copy ? 1'b0 : (coef_commit ? 1'b1 : pend_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
    end
  end

  // The table is padded to a power of two so any read index is legal; pad entries read 0.
  for (genvar gi = 0; gi < 2**AW; gi++) begin : g_tap
    if (gi <= ORDER) begin : g_live
      logic signed [CWIDTH-1:0] shd_q, shd_d, act_q;
      logic hit;
      assign hit   = coef_we && (coef_addr == AW'(gi));
      assign shd_d = hit ? coef_data : shd_q;
      // The copy takes shd_d, so a write in the same cycle as the copy is included.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          shd_q <= '0;
          act_q <= '0;
        end else begin
          shd_q <= shd_d;
          if (copy) act_q <= shd_d;
        end
      end
      assign act_w[gi] = act_q;
    end else begin : g_pad
      assign act_w[gi] = '0;
    end
  end

  assign rd_coef_a = act_w[rd_idx_a];
  assign rd_coef_b = act_w[rd_idx_b];

endmodule

// File: rtl/allpass_mc.sv
// allpass_mc -- multi-channel IIR allpass-style filter, one MAC step per cycle.
//   clk, rst (async, active-low)
//   in_valid/in_ready/in_ch/in_data     : sample input handshake
//   out_valid/out_ready/out_ch/out_data : result output handshake (held under backpressure)
//   coef_we/coef_addr/coef_data/coef_commit : coefficient shadow writes and commit
//   clr  : zero all channel histories (deferred while a sample is in flight)
//   busy : engine not idle
module allpass_mc
  import allpass_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int CWIDTH   = 16,
  parameter int CFRAC    = 15,
  parameter int ORDER    = 4,
  parameter int CHANNELS = 2,
  localparam int CHW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int AW      = $clog2(ORDER + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CHW-1:0]           in_ch,
  input  logic signed [WIDTH-1:0]  in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CHW-1:0]           out_ch,
  output logic signed [WIDTH-1:0]  out_data,
  input  logic                     coef_we,
  input  logic [AW-1:0]            coef_addr,
  input  logic signed [CWIDTH-1:0] coef_data,
  input  logic                     coef_commit,
  input  logic                     clr,
  output logic                     busy
);

  localparam int SW  = $clog2(ORDER + 2);  // step counter also covers the finalize cycle
  localparam int ACC = acc_width(WIDTH, CWIDTH, ORDER);
  localparam int PW  = WIDTH + CWIDTH;

  state_e state_q, state_d;
  logic                    run_q, clr_pend_q;
  logic [SW-1:0]           step_q, tap_sel;
  logic [CHW-1:0]          ch_q, ch_rd, out_ch_q;
  logic signed [WIDTH-1:0] x_q, out_data_q, out_sat, x_tap, y_tap, mul_a, mul_b;
  logic signed [ACC-1:0]   acc_q, acc_d;
  logic signed [PW-1:0]    pa, pb;
  logic signed [CWIDTH-1:0] coef_a, coef_b;
  logic [AW-1:0]           idx_a, idx_b;
  logic accept, last_step, step0, ch_ok, hist_push, hist_clr;
  logic [2**CHW-1:0]       ch_map;
  logic signed [WIDTH-1:0] xh_w [CHANNELS][1:ORDER];
  logic signed [WIDTH-1:0] yh_w [CHANNELS][1:ORDER];

  // Lookup of legal channel numbers; avoids comparing ch_q against a constant.
  for (genvar gi = 0; gi < 2**CHW; gi++) begin : g_chmap
    assign ch_map[gi] = (gi < CHANNELS);
  end

  assign ch_ok     = ch_map[ch_q];
  assign ch_rd     = ch_ok ? ch_q : '0;
  assign step0     = (step_q == '0);
  // The cycle after step ORDER only rounds/saturates and moves to OUT.
  assign last_step = (step_q == SW'(ORDER + 1));
  assign hist_push = (state_q == ST_MAC) && last_step && ch_ok;
  assign hist_clr  = (state_q == ST_IDLE) && (clr || clr_pend_q);
  assign out_sat   = WIDTH'(round_sat({{(128 - ACC){acc_q[ACC-1]}}, acc_q}, CFRAC, WIDTH));

  allpass_coef_bank #(.CWIDTH(CWIDTH), .ORDER(ORDER), .AW(AW)) u_coef (
    .clk        (clk),
    .rst        (rst),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .coef_commit(coef_commit),
    .commit_en  (state_q == ST_IDLE),
    .rd_idx_a   (idx_a),
    .rd_idx_b   (idx_b),
    .rd_coef_a  (coef_a),
    .rd_coef_b  (coef_b)
  );

  // MAC datapath: step 0 loads c0*x, step k adds ck*x[n-k] - c(ORDER+1-k)*y[n-k].
  always_comb begin
    tap_sel = (step0 || last_step) ? SW'(1) : step_q;
    idx_a   = AW'(step_q);
    idx_b   = AW'(SW'(ORDER + 1) - step_q);
    x_tap   = xh_w[ch_rd][tap_sel];
    y_tap   = yh_w[ch_rd][tap_sel];
    mul_a   = step0 ? x_q : x_tap;
    mul_b   = step0 ? '0 : y_tap;
    pa      = mul_a * coef_a;
    pb      = mul_b * coef_b;
    acc_d   = (step0 ? '0 : acc_q)
            + {{(ACC - PW){pa[PW-1]}}, pa}
            - {{(ACC - PW){pb[PW-1]}}, pb};
  end

  // Per-channel history: slot k holds x[n-k] / y[n-k].
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic signed [WIDTH-1:0] xs_q [1:ORDER];
    logic signed [WIDTH-1:0] ys_q [1:ORDER];
    logic push;
    assign push = hist_push && (ch_q == CHW'(gi));
    always_ff @(posedge clk or negedge rst) begin
      if (!rst || hist_clr) begin
        for (int k = 1; k <= ORDER; k++) begin
          xs_q[k] <= '0;
          ys_q[k] <= '0;
        end
      end else if (push) begin
        xs_q[1] <= x_q;
        ys_q[1] <= out_sat;
        for (int k = 2; k <= ORDER; k++) begin
          xs_q[k] <= xs_q[k-1];
          ys_q[k] <= ys_q[k-1];
        end
      end
    end
    for (genvar gt = 1; gt <= ORDER; gt++) begin : g_rd
      assign xh_w[gi][gt] = xs_q[gt];
      assign yh_w[gi][gt] = ys_q[gt];
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)    state_d = ST_MAC;
      ST_MAC:  if (last_step) state_d = ST_OUT;
      ST_OUT:  if (out_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // FSM outputs; run_q keeps in_ready low until the first edge after reset.
  always_comb begin
    in_ready  = run_q && (state_q == ST_IDLE) && !clr;
    accept    = in_valid && in_ready;
    busy      = (state_q != ST_IDLE);
    out_valid = (state_q == ST_OUT);
    out_data  = out_data_q;
    out_ch    = out_ch_q;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q      <= 1'b0;
      clr_pend_q <= 1'b0;
      step_q     <= '0;
      ch_q       <= '0;
      x_q        <= '0;
      acc_q      <= '0;
      out_data_q <= '0;
      out_ch_q   <= '0;
    end else begin
      run_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          clr_pend_q <= 1'b0;
          if (accept) begin
            ch_q   <= in_ch;
            x_q    <= in_data;
            step_q <= '0;
          end
        end
        ST_MAC: begin
          if (clr) clr_pend_q <= 1'b1;
          if (!last_step) begin
            acc_q  <= acc_d;
            step_q <= step_q + SW'(1);
          end else begin
            out_data_q <= ch_ok ? out_sat : '0;
            out_ch_q   <= ch_q;
          end
        end
        ST_OUT: begin
          if (clr) clr_pend_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_allpass_mc.sv
module tb_allpass_mc;

  logic        clk, rst;
  logic        in_valid, in_ready, in_ch;
  logic [15:0] in_data;
  logic        out_valid, out_ready, out_ch;
  logic [15:0] out_data;
  logic        coef_we, coef_commit, clr, busy;
  logic [1:0]  coef_addr;
  logic [15:0] coef_data;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    logic [15:0] data;
    logic        ch;
    string       name;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  allpass_mc #(.WIDTH(16), .CWIDTH(16), .CFRAC(15), .ORDER(2), .CHANNELS(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .out_data(out_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .coef_commit(coef_commit), .clr(clr), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
  endtask

  // Monitor: every accepted output is compared against the oldest expectation.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_output: got ch%0d 0x%0h required none", out_ch, out_data);
      end else begin
        mon_e = exp_q.pop_front();
        $display("out %-12s ch=%0d data=0x%04h (exp ch=%0d 0x%04h)",
                 mon_e.name, out_ch, out_data, mon_e.ch, mon_e.data);
        chk({mon_e.name, "_data"}, {16'h0, out_data}, {16'h0, mon_e.data});
        chk({mon_e.name, "_ch"}, {31'h0, out_ch}, {31'h0, mon_e.ch});
      end
    end
  end

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk({name, "_idle_timeout"}, {31'h0, busy}, 32'h0);
    @(posedge clk); #1;
  endtask

  task automatic load(input logic [15:0] c0, input logic [15:0] c1, input logic [15:0] c2);
    logic [15:0] c [3];
    c[0] = c0; c[1] = c1; c[2] = c2;
    wait_idle("load");
    for (int i = 0; i < 3; i++) begin
      coef_we = 1'b1; coef_addr = 2'(i); coef_data = c[i]; coef_commit = (i == 2);
      @(posedge clk); #1;
    end
    coef_we = 1'b0; coef_commit = 1'b0;
  endtask

  task automatic do_clr();
    wait_idle("clr");
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  // Offers one sample; the expectation is queued at the moment of acceptance.
  task automatic send(input logic ch, input logic [15:0] d, input logic [15:0] e,
                      input bit expect_out, input string name);
    int n = 0;
    exp_t t;
    in_ch = ch; in_data = d; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total_cnt++;
      $display("FAIL %s_accept_timeout: got in_ready=0 required 1", name);
    end else begin
      $display("in  %-12s ch=%0d data=0x%04h", name, ch, d);
      if (expect_out) begin
        t.data = e; t.ch = ch; t.name = name;
        exp_q.push_back(t);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b0; in_valid = 1'b0; in_ch = 1'b0; in_data = '0; out_ready = 1'b1;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0; coef_commit = 1'b0; clr = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", {31'h0, in_ready}, 32'h0);
    chk("reset_out_valid", {31'h0, out_valid}, 32'h0);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_out_data", {16'h0, out_data}, 32'h0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk) chk("reset_ready_before_edge", {31'h0, in_ready}, 32'h0);
    @(negedge clk) chk("reset_ready_after_edge", {31'h0, in_ready}, 32'h1);
    @(posedge clk); #1;

    // Impulse, with latency from accept to out_valid
    load(16'h4000, 16'h0000, 16'h0000);
    send(1'b0, 16'h4000, 16'h2000, 1, "impulse");
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("impulse_latency", n, 32'd4);
    @(posedge clk); #1;

    // Saturation on the second sample
    load(16'h7FFF, 16'h7FFF, 16'h0000);
    do_clr();
    send(1'b0, 16'h7FFF, 16'h7FFE, 1, "sat_first");
    send(1'b0, 16'h7FFF, 16'h7FFF, 1, "sat_second");

    // Channel isolation, then a negative result from both histories
    load(16'h4000, 16'h4000, 16'h0000);
    do_clr();
    send(1'b0, 16'h4000, 16'h2000, 1, "iso_ch0_a");
    send(1'b1, 16'h0000, 16'h0000, 1, "iso_ch1");
    send(1'b0, 16'h0000, 16'h2000, 1, "iso_ch0_b");
    send(1'b0, 16'h1000, 16'hF800, 1, "iso_ch0_neg");

    // Rounding half up and negative-range / positive saturation
    load(16'h4000, 16'h0000, 16'h0000);
    send(1'b0, 16'hFFFF, 16'h0000, 1, "round_m1");
    send(1'b0, 16'h0001, 16'h0001, 1, "round_p1");
    send(1'b1, 16'h8000, 16'hC000, 1, "neg_full");
    load(16'h8000, 16'h0000, 16'h0000);
    send(1'b1, 16'h8000, 16'h7FFF, 1, "sat_negneg");

    // Backpressure: output held, no new input accepted, one transfer
    load(16'h4000, 16'h4000, 16'h0000);
    do_clr();
    out_ready = 1'b0;
    send(1'b1, 16'h4000, 16'h2000, 1, "backpressure");
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'h0, out_valid}, 32'h1);
      chk("bp_data", {16'h0, out_data}, 32'h2000);
      chk("bp_ch", {31'h0, out_ch}, 32'h1);
      chk("bp_in_ready", {31'h0, in_ready}, 32'h0);
      @(negedge clk);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk) chk("bp_single", {31'h0, out_valid}, 32'h0);
    @(posedge clk); #1;

    // Commit while a sample is in flight
    load(16'h4000, 16'h0000, 16'h0000);
    send(1'b0, 16'h4000, 16'h2000, 1, "commit_old");
    chk("commit_busy", {31'h0, busy}, 32'h1);
    coef_we = 1'b1; coef_addr = 2'd0; coef_data = 16'h2000; coef_commit = 1'b1;
    @(posedge clk); #1;
    coef_we = 1'b0; coef_commit = 1'b0;
    send(1'b0, 16'h4000, 16'h1000, 1, "commit_new");

    // Reset in the middle of MAC aborts the sample and clears everything
    load(16'h4000, 16'h4000, 16'h0000);
    do_clr();
    send(1'b0, 16'h4000, 16'h2000, 1, "pre_rst");
    wait_idle("pre_rst");
    send(1'b0, 16'h1234, 16'h0000, 0, "aborted");
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", {31'h0, in_ready}, 32'h0);
    chk("midrst_busy", {31'h0, busy}, 32'h0);
    chk("midrst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("midrst_out_data", {16'h0, out_data}, 32'h0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk) chk("midrst_ready_before_edge", {31'h0, in_ready}, 32'h0);
    @(negedge clk) chk("midrst_ready_after_edge", {31'h0, in_ready}, 32'h1);
    @(posedge clk); #1;
    load(16'h4000, 16'h4000, 16'h0000);
    send(1'b0, 16'h4000, 16'h2000, 1, "post_rst");
    send(1'b0, 16'h4000, 16'h4000, 1, "hist_used");
    do_clr();
    send(1'b0, 16'h4000, 16'h2000, 1, "post_clr");

    // Drain
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("queue_drained", exp_q.size(), 32'h0);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/allpass_mc.md
ALLPASS_MC -- requirements
Module: allpass_mc

Interface
REQ-001 Parameter WIDTH, 16, sample width (signed two's complement).
REQ-002 Parameter CWIDTH, 16, coefficient width (signed).
REQ-003 Parameter CFRAC, 15, coefficient fractional bits; output scale 2^-CFRAC.
REQ-004 Parameter ORDER, 4, history depth per channel (taps c0..cORDER), ORDER >= 1.
REQ-005 Parameter CHANNELS, 2, independent channels sharing one coefficient set; CHW = max(1, clog2(CHANNELS)).
REQ-006 Ports: clk in 1 clock; rst in 1 reset, asynchronous, active-low (one clock; reset is asynchronous and active-low).
REQ-007 Ports: in_valid in 1; in_ready out 1; in_ch in CHW; in_data in WIDTH signed.
REQ-008 Ports: out_valid out 1; out_ready in 1; out_ch out CHW; out_data out WIDTH signed.
REQ-009 Ports: coef_we in 1; coef_addr in clog2(ORDER+1); coef_data in CWIDTH signed; coef_commit in 1.
REQ-010 Ports: clr in 1, zeroes all channel histories; busy out 1, high when FSM not IDLE.

Function
REQ-011 Per channel: y[n] = c0*x[n] + sum k=1..ORDER (ck*x[n-k] - c(ORDER+1-k)*y[n-k]), scaled by 2^-CFRAC.
REQ-012 Accumulator width ACC = WIDTH+CWIDTH+clog2(2*ORDER+1)+1; no internal overflow.
REQ-013 Output rounding: add 2^(CFRAC-1), arithmetic shift right CFRAC (round half up).
REQ-014 Output saturation to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; saturated value also stored as y history.
REQ-015 FSM states IDLE, MAC, OUT; in_ready = 1 only in IDLE and not clr.
REQ-016 IDLE->MAC on in_valid&in_ready; latch in_ch, in_data; step counter = 0.
REQ-017 MAC: step 0 loads c0*x; steps 1..ORDER add ck*x[n-k] and subtract c(ORDER+1-k)*y[n-k] (two multipliers, one step per cycle).
REQ-018 MAC->OUT after step ORDER; out_valid asserted first cycle after, i.e. ORDER+2 cycles after accept.
REQ-019 On entering OUT: shift channel histories (x[n] and y[n] into slot 1); other channels untouched.
REQ-020 OUT: out_data, out_ch held stable while out_valid & !out_ready; OUT->IDLE on out_ready.
REQ-021 in_ch >= CHANNELS: sample accepted, no history update, out_data = 0, out_ch = in_ch.
REQ-022 Coefficients: coef_we writes shadow bank[coef_addr]; coef_addr > ORDER ignored.
REQ-023 coef_commit latches a pending flag; shadow copied to active bank only in IDLE, before any same-cycle accept; a sample in MAC/OUT always uses one consistent bank.
REQ-024 coef_we and commit same cycle: write lands in shadow before the copy.
REQ-025 clr in IDLE: all histories zero next cycle; clr in MAC/OUT: deferred until return to IDLE, current sample completes with old history.

Reset
REQ-026 rst low: FSM IDLE, out_valid 0, out_data 0, out_ch 0, busy 0, in_ready 0 during reset.
REQ-027 rst low: all histories zero, active and shadow coefficients zero, commit/clr pending flags cleared.
REQ-028 Reset mid-MAC or mid-OUT aborts the sample; no output produced for it.
REQ-029 in_ready rises first clk edge after rst deasserts.

Structure
REQ-030 Shared package allpass_pkg: FSM state enum, ACC width function, round/saturate function.
REQ-031 History storage as registers indexed [channel][tap]; no RAM inference required.
REQ-032 One sub-module allpass_coef_bank: shadow/active registers, commit logic, read port by tap index.

Verification (WIDTH=16, CWIDTH=16, CFRAC=15, ORDER=2, CHANNELS=2)
REQ-033 Impulse: c0=0x4000 others 0, ch0 x=0x4000 -> out_data 0x2000 ch0, out_valid 4 cycles after accept.
REQ-034 Saturation: c0=c1=0x7FFF, c2=0, ch0 x=0x7FFF then 0x7FFF -> 0x7FFE then 0x7FFF (saturated).
REQ-035 Isolation: c0=0x4000, c1=0x4000, ch0 x=0x4000, ch1 x=0, ch0 x=0 -> 0x2000, 0x0000, 0x2000.
REQ-036 Backpressure: out_ready low 5 cycles -> out_data/out_ch stable, in_ready 0, then single transfer.
REQ-037 Commit during MAC: new c0=0x2000 committed mid-sample -> current sample uses old c0, next uses 0x2000.
REQ-038 Reset mid-MAC then same input -> output equals first-sample-from-zero-history value; clr in IDLE likewise.
